// File: rtl/cla_pkg.sv
// Shared constants and state encoding for the multi-word CLA sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cla_pkg;

    localparam int CLA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/carrylookahead32bit.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
// Latency: purely combinational.
// Backpressure: none.
module carrylookahead32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [7:0]  gg;
    logic [7:0]  gp;
    logic [8:0]  bc;
    logic [32:0] c;

    // Group generate/propagate, inter-group carries, then per-bit carries inside each group.
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '0;
        bc = '0;
        c  = '0;
        bc[0] = cin;
        for (int k = 0; k < 8; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
            bc[k+1] = gg[k] | (gp[k] & bc[k]);
        end
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = bc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & bc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & bc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & bc[k]);
        end
        c[32] = bc[8];
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];

endmodule

// File: rtl/cla_multiword_seq.sv
// Multi-precision add/sub: streams WORDS x 32-bit operands through one shared CLA, LSW first.
// Latency: accept at edge E0, out_valid from edge E0+WORDS; issue interval WORDS+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
module cla_multiword_seq
    import cla_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CLA_W*WORDS-1:0] in_a,
    input  logic [CLA_W*WORDS-1:0] in_b,
    input  logic                   in_cin,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CLA_W*WORDS-1:0] out_sum,
    output logic                   out_cout,
    output logic                   out_ovf
);

    localparam int N  = CLA_W * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SH = $clog2(CLA_W);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     idx;
    logic [IW+SH-1:0]  base;
    logic [N-1:0]      a_reg;
    logic [N-1:0]      b_reg;      // already inverted for subtract
    logic [N-1:0]      sum_reg;
    logic              carry_reg;
    logic              ovf_reg;
    logic [CLA_W-1:0]  cla_sum;
    logic              cla_cout;

    // Bit offset of the current word: idx * CLA_W as a shift.
    assign base = {idx, {SH{1'b0}}};

    carrylookahead32bit u_cla (
        .a    (a_reg[base +: CLA_W]),
        .b    (b_reg[base +: CLA_W]),
        .cin  (carry_reg),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = RUN;
            RUN:     if (idx == LAST)  state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Operand latch, per-word accumulation and overflow capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b ^ {N{in_sub}};
                        carry_reg <= in_sub | in_cin;   // subtract forces +1
                        idx       <= '0;
                    end
                end
                RUN: begin
                    sum_reg[base +: CLA_W] <= cla_sum;
                    carry_reg              <= cla_cout;
                    if (idx == LAST) begin
                        // Same-sign operands whose result flips sign.
                        ovf_reg <= (a_reg[N-1] == b_reg[N-1]) && (cla_sum[CLA_W-1] != a_reg[N-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_sum   = sum_reg;
    assign out_cout  = carry_reg;
    assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Bench for cla_multiword_seq with WORDS=4: vector table, random vectors, backpressure and reset.
// Latency: checks out_valid rises WORDS edges after acceptance.
// Backpressure: exercises a 10-cycle hold of out_ready low.
module tb_cla_multiword_seq;

    localparam int W = 4;
    localparam int N = 32 * W;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic         sub;
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    exp_t sb[$];
    vec_t vecs[9];
    int   n_vec = 0;
    int   n_err = 0;

    cla_multiword_seq #(.WORDS(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [N-1:0] bb;
        logic [N:0]   s;
        bb     = sub ? ~b : b;
        s      = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, (sub ? 1'b1 : cin)};
        e.sum  = s[N-1:0];
        e.cout = s[N];
        e.ovf  = (a[N-1] == bb[N-1]) && (s[N-1] != a[N-1]);
        return e;
    endfunction

    // Drive a request (caller is between edges), wait for acceptance, then scramble inputs.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                         input logic sub, input exp_t e, input bit push, output int waited);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: in_ready got 0 want 1");
        end
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = ~a; in_b = ~b; in_cin = ~cin; in_sub = ~sub;
    endtask

    // Wait for out_valid, check latency and result; with out_ready high check the one-cycle pulse.
    task automatic collect(input string name);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 60);
        check({name, "_latency"}, N'(n - 1), N'(W));
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL %s_scoreboard: got empty queue want 1 entry", name);
        end else begin
            e = sb.pop_front();
            check({name, "_sum"},  out_sum,  e.sum);
            check({name, "_cout"}, N'(out_cout), N'(e.cout));
            check({name, "_ovf"},  N'(out_ovf),  N'(e.ovf));
        end
        if (out_ready) begin
            @(negedge clk);
            check({name, "_pulse"},    N'(out_valid), N'(0));
            check({name, "_in_ready"}, N'(in_ready),  N'(1));
        end
    endtask

    initial begin
        #200000;
        n_vec++; n_err++;
        $display("FAIL watchdog: got timeout want finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        int   waited;
        int   pulses;
        exp_t e;
        logic [N-1:0] ra, rb, held;

        vecs[0] = '{a: '1, b: N'(1), cin: 0, sub: 0, sum: '0, cout: 1, ovf: 0};
        vecs[1] = '{a: N'(32'hFFFF_FFFF), b: N'(1), cin: 0, sub: 0,
                    sum: N'(64'h1_0000_0000), cout: 0, ovf: 0};
        vecs[2] = '{a: N'(5), b: N'(7), cin: 0, sub: 1, sum: {{(N-4){1'b1}}, 4'hE}, cout: 0, ovf: 0};
        vecs[3] = '{a: N'(7), b: N'(5), cin: 1, sub: 1, sum: N'(2), cout: 1, ovf: 0};
        vecs[4] = '{a: {1'b0, {(N-1){1'b1}}}, b: N'(1), cin: 0, sub: 0,
                    sum: {1'b1, {(N-1){1'b0}}}, cout: 0, ovf: 1};
        vecs[5] = '{a: '0, b: '0, cin: 1, sub: 0, sum: N'(1), cout: 0, ovf: 0};
        vecs[6] = '{a: '0, b: '0, cin: 0, sub: 1, sum: '0, cout: 1, ovf: 0};
        vecs[7] = '{a: {1'b1, {(N-1){1'b0}}}, b: {1'b1, {(N-1){1'b0}}}, cin: 0, sub: 0,
                    sum: '0, cout: 1, ovf: 1};
        vecs[8] = '{a: {1'b1, {(N-1){1'b0}}}, b: N'(1), cin: 0, sub: 1,
                    sum: {1'b0, {(N-1){1'b1}}}, cout: 1, ovf: 1};

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  N'(in_ready),  N'(0));
        check("rst_out_valid", N'(out_valid), N'(0));
        check("rst_out_sum",   out_sum,       '0);
        check("rst_out_cout",  N'(out_cout),  N'(0));
        check("rst_out_ovf",   N'(out_ovf),   N'(0));
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", N'(in_ready), N'(1));

        // Table-driven vectors.
        for (int i = 0; i < 9; i++) begin
            e = '{sum: vecs[i].sum, cout: vecs[i].cout, ovf: vecs[i].ovf};
            issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, e, 1'b1, waited);
            collect($sformatf("vec%0d", i));
        end

        // Random vectors against the wide reference sum.
        for (int i = 0; i < 8; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            if (i == 3) rb = ~ra;   // full propagate chain
            issue(ra, rb, 1'($urandom), 1'(i & 1), model(ra, rb, 1'(i >> 1), 1'(i & 1)), 1'b0, waited);
            // model above used a guessed cin; recompute with the value actually driven
            sb.push_back(model(ra, rb, ~in_cin, ~in_sub));
            collect($sformatf("rnd%0d", i));
        end

        // Backpressure: result must be held 10 cycles with in_ready low.
        out_ready = 1'b0;
        e = model(N'(100), N'(23), 1'b0, 1'b0);
        issue(N'(100), N'(23), 1'b0, 1'b0, e, 1'b1, waited);
        collect("bp");
        held = out_sum;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid_held", N'(out_valid), N'(1));
            check("bp_sum_held",   out_sum,       N'(123));
            check("bp_in_ready",   N'(in_ready),  N'(0));
        end
        check("bp_sum_stable", out_sum, held);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", N'(out_valid), N'(0));
        check("bp_release_ready", N'(in_ready),  N'(1));
        issue(N'(9), N'(4), 1'b0, 1'b1, model(N'(9), N'(4), 1'b0, 1'b1), 1'b1, waited);
        check("bp_next_accept_wait", N'(waited), N'(0));
        collect("bp_next");

        // Reset after word 1 of an operation aborts it.
        issue(N'(11), N'(22), 1'b0, 1'b0, e, 1'b0, waited);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid",    N'(out_valid), N'(0));
        check("mid_rst_sum",      out_sum,       '0);
        check("mid_rst_cout",     N'(out_cout),  N'(0));
        check("mid_rst_ovf",      N'(out_ovf),   N'(0));
        check("mid_rst_in_ready", N'(in_ready),  N'(0));
        rst_n = 1'b1;
        #1;
        check("mid_rel_in_ready", N'(in_ready), N'(1));
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("mid_no_pulse", N'(pulses), N'(0));
        e = '{sum: N'(3), cout: 1'b0, ovf: 1'b0};
        issue(N'(1), N'(2), 1'b0, 1'b0, e, 1'b1, waited);
        collect("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cla_multiword_seq.md
# cla_multiword_seq

Multi-precision add/subtract sequencer built around one shared `carrylookahead32bit` instance. It accepts two `WORDS`×32-bit operands over a valid/ready handshake. It then streams them through the 32-bit CLA one word per cycle, least-significant word first, carrying `cout` forward in a register. It returns the full-width result, carry-out and signed overflow over a second valid/ready handshake, which gives the design wide adds without a wide CLA tree.

## Interface
- `WORDS`, 4: number of 32-bit words per operand; legal range 1..16.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  operand request valid.
- `in_ready`  out  1  block can accept a request; high only in IDLE.
- `in_a`  in  32*WORDS  operand A; word i is `[32i+31:32i]`.
- `in_b`  in  32*WORDS  operand B.
- `in_cin`  in  1  carry-in for add; ignored when `in_sub`=1.
- `in_sub`  in  1  0 computes A+B+cin; 1 computes A−B, implemented as A+~B+1.
- `out_valid`  out  1  result valid; held until accepted.
- `out_ready`  in  1  consumer accepts result.
- `out_sum`  out  32*WORDS  result.
- `out_cout`  out  1  final carry; for subtract, 1 means no borrow.
- `out_ovf`  out  1  two's-complement overflow of the full-width result.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch A, B^{32*WORDS{sub}}, sub flag; carry_reg ← sub ? 1 : `in_cin`; idx ← 0; go to RUN.
- **RUN**
  - CLA inputs: a=A[idx], b=B'[idx], cin=carry_reg.
  - Each edge: sum_reg[idx] ← CLA sum; carry_reg ← CLA cout; idx ← idx+1.
  - On idx=WORDS−1: go to DONE; capture `out_ovf` = (A_msb == B'_msb) && (sum_msb != A_msb).
- **DONE**
  - `out_valid`=1; `out_sum`=sum_reg; `out_cout`=carry_reg.
  - On `out_ready`: go to IDLE.
- Requests cannot overlap: `in_ready`=0 in RUN and DONE. `in_valid` while not ready is ignored; the source must hold it.
- Operands are latched at acceptance. Changes to `in_a`/`in_b` after acceptance do not affect the result.
- Index counter width is max(1, $clog2(WORDS)). It never exceeds WORDS−1; no wrap-around is used.
- `WORDS`=1: exactly one RUN cycle.

## Timing
- Reset (`rst_n`=0 at an edge) forces:
  - state=IDLE, idx=0, carry_reg=0, sum_reg=0;
  - `out_valid`=0, `out_sum`=0, `out_cout`=0, `out_ovf`=0.
  - `in_ready` is forced to 0 while `rst_n`=0 and is 1 in the first cycle after release.
- Reset mid-RUN or in DONE aborts the operation. No result is emitted, and the partial sum is cleared.
- Latency: accept at edge E0; `out_valid` rises after edge E0+WORDS.
- Minimum issue interval is WORDS+2 cycles: RUN×WORDS, DONE, IDLE.
- With `out_ready` held high, `out_valid` is high for exactly one cycle.
- `out_*` are registered and stable throughout DONE. There is no combinational path from `in_*` or `out_ready` to `out_*`.
- `in_ready` and `out_valid` are decoded from the state register only.

## Structure
- Shared package `cla_pkg`:
  - `CLA_W`=32;
  - state enum {IDLE, RUN, DONE}.
- One sub-module: a single `carrylookahead32bit` instance, ports a, b, cin, sum, cout, purely combinational.
- Word select on A/B' and word write into sum_reg are indexed part-selects; no per-word adders.

## Test plan
All scenarios use WORDS=4.
- **Full carry ripple:** A=all-ones (128b), B=1, cin=0, add -> `out_sum`=0, `out_cout`=1, `out_ovf`=0; `out_valid` rises 4 cycles after acceptance.
- **Single word carry:** A=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, B=1 -> `out_sum`=0x1_0000_0000, `out_cout`=0.
- **Subtract with borrow:** A=5, B=7, sub=1 -> `out_sum`=2^128−2 (0xFFFF…FFFE), `out_cout`=0, `out_ovf`=0. Also A=7, B=5 gives 2 with `out_cout`=1.
- **Signed overflow:** A=0x7FFF…FFFF, B=1, add -> `out_sum`=0x8000…0000, `out_ovf`=1, `out_cout`=0.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in DONE -> `out_valid`/`out_sum` held and `in_ready`=0 throughout. Raise `out_ready` -> IDLE on the next edge; a new request is accepted the cycle after.
- **Reset mid-operation:** assert `rst_n`=0 for one edge after word 1 -> all outputs 0 and `in_ready`=1 after release, no `out_valid` pulse. A following request completes correctly with sum 3 for A=1, B=2.
